// File: rtl/rob_nway_ptr_if.sv
// Dispatch, completion and retire bundle for the N-way reorder buffer.
// Exception signals exist only when ROB_EXCEPTION_EN is defined.
interface rob_nway_ptr_if #(
    parameter int N_WAY = 2,
    parameter int N_ROB = 32,
    parameter int N_CDB = 2,
    parameter int TAG_W = 6
);
    localparam int PW = $clog2(N_ROB) + 1;
    localparam int CW = $clog2(N_WAY) + 1;

    logic [N_WAY-1:0]       dis_valid;
    logic [N_WAY*TAG_W-1:0] dis_tag;
    logic [N_WAY*TAG_W-1:0] dis_told;
    logic [N_WAY-1:0]       dis_branch;
    logic [N_WAY-1:0]       dis_accept;
    logic [CW-1:0]          dis_free_cnt;
    logic [N_CDB-1:0]       cdb_valid;
    logic [N_CDB*TAG_W-1:0] cdb_tag;
    logic [N_CDB-1:0]       cdb_mispred;
    logic [N_WAY-1:0]       ret_valid;
    logic [N_WAY*TAG_W-1:0] ret_tag;
    logic [N_WAY*TAG_W-1:0] ret_told;
    logic                   squash;
    logic [N_ROB-1:0]       squash_vec;
    logic [N_ROB*TAG_W-1:0] squash_tags;
    logic [PW-1:0]          occupancy;
`ifdef ROB_EXCEPTION_EN
    logic [N_CDB-1:0]       cdb_exc;
    logic                   exc_valid;
    logic [TAG_W-1:0]       exc_told;
`endif

    modport master (
`ifdef ROB_EXCEPTION_EN
        output cdb_exc,
        input  exc_valid, exc_told,
`endif
        output dis_valid, dis_tag, dis_told, dis_branch,
        output cdb_valid, cdb_tag, cdb_mispred,
        input  dis_accept, dis_free_cnt, ret_valid, ret_tag, ret_told,
        input  squash, squash_vec, squash_tags, occupancy
    );

    modport slave (
`ifdef ROB_EXCEPTION_EN
        input  cdb_exc,
        output exc_valid, exc_told,
`endif
        input  dis_valid, dis_tag, dis_told, dis_branch,
        input  cdb_valid, cdb_tag, cdb_mispred,
        output dis_accept, dis_free_cnt, ret_valid, ret_tag, ret_told,
        output squash, squash_vec, squash_tags, occupancy
    );
endinterface

// File: rtl/rob_nway_ptr.sv
// Circular pointer-based reorder buffer: N-way dispatch/retire, CDB completion by tag,
// squash on retiring mispredicted branch. ROB_EXCEPTION_EN adds precise exception flush.
module rob_nway_ptr #(
    parameter int N_WAY = 2,
    parameter int N_ROB = 32,
    parameter int N_CDB = 2,
    parameter int TAG_W = 6
) (
    input logic           clock,
    input logic           reset,
    rob_nway_ptr_if.slave rob
);
    localparam int IW = $clog2(N_ROB);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(N_WAY) + 1;

    logic [PW-1:0]    head, tail, occ, free_cnt;
    logic [N_ROB-1:0] e_valid, e_branch, e_complete, e_mispred;
    logic [TAG_W-1:0] e_tag  [N_ROB];
    logic [TAG_W-1:0] e_told [N_ROB];
`ifdef ROB_EXCEPTION_EN
    logic [N_ROB-1:0] e_exc;
`endif

    logic [IW-1:0] ret_idx  [N_WAY];
    logic [IW-1:0] dis_slot [N_WAY];
    logic [PW-1:0] n_ret, n_acc, kill_next;
    logic          kill, kill_self;
    logic [IW-1:0] kill_off;

    assign occ              = tail - head;
    assign free_cnt         = PW'(N_ROB) - occ;
    assign rob.occupancy    = occ;
    assign rob.dis_free_cnt = (free_cnt >= PW'(N_WAY)) ? CW'(N_WAY) : CW'(free_cnt);
    assign rob.squash       = kill;

    // In-order retire scan; a mispredicted branch (or excepting entry) ends the scan and kills.
    always_comb begin
        logic stop;
        stop          = 1'b0;
        n_ret         = '0;
        kill          = 1'b0;
        kill_self     = 1'b0;
        kill_off      = '0;
        rob.ret_valid = '0;
        rob.ret_tag   = '0;
        rob.ret_told  = '0;
`ifdef ROB_EXCEPTION_EN
        rob.exc_valid = 1'b0;
        rob.exc_told  = '0;
`endif
        for (int i = 0; i < N_WAY; i++) begin
            ret_idx[i] = head[IW-1:0] + IW'(i);
            if (!stop) begin
                if (!e_valid[ret_idx[i]] || !e_complete[ret_idx[i]]) begin
                    stop = 1'b1;
                end
`ifdef ROB_EXCEPTION_EN
                else if (e_exc[ret_idx[i]]) begin
                    stop          = 1'b1;
                    kill          = 1'b1;
                    kill_self     = 1'b1;
                    kill_off      = IW'(i);
                    rob.exc_valid = 1'b1;
                    rob.exc_told  = e_told[ret_idx[i]];
                end
`endif
                else begin
                    rob.ret_valid[i]               = 1'b1;
                    rob.ret_tag[i*TAG_W +: TAG_W]  = e_tag[ret_idx[i]];
                    rob.ret_told[i*TAG_W +: TAG_W] = e_told[ret_idx[i]];
                    n_ret                          = n_ret + PW'(1);
                    if (e_branch[ret_idx[i]] && e_mispred[ret_idx[i]]) begin
                        stop     = 1'b1;
                        kill     = 1'b1;
                        kill_off = IW'(i);
                    end
                end
            end
        end
        kill_next = head + PW'(kill_off) + (kill_self ? PW'(0) : PW'(1));
    end

    always_comb begin
        logic [IW-1:0] off;
        off             = '0;
        rob.squash_vec  = '0;
        rob.squash_tags = '0;
        for (int e = 0; e < N_ROB; e++) begin
            off = IW'(e) - head[IW-1:0];
            if (kill && e_valid[e] && (off > kill_off || (kill_self && off == kill_off))) begin
                rob.squash_vec[e]                  = 1'b1;
                rob.squash_tags[e*TAG_W +: TAG_W]  = e_tag[e];
            end
        end
    end

    // Accepted lanes pack into consecutive tail slots; slots freed this cycle are not reused.
    always_comb begin
        logic [PW-1:0] below;
        below          = '0;
        n_acc          = '0;
        rob.dis_accept = '0;
        for (int k = 0; k < N_WAY; k++) begin
            dis_slot[k] = tail[IW-1:0] + below[IW-1:0];
            if (rob.dis_valid[k]) begin
                if (!kill && free_cnt > below) begin
                    rob.dis_accept[k] = 1'b1;
                    n_acc             = n_acc + PW'(1);
                end
                below = below + PW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            e_valid    <= '0;
            e_complete <= '0;
            e_mispred  <= '0;
`ifdef ROB_EXCEPTION_EN
            e_exc      <= '0;
`endif
        end else if (kill) begin
            head       <= kill_next;
            tail       <= kill_next;
            e_valid    <= '0;
            e_complete <= '0;
            e_mispred  <= '0;
`ifdef ROB_EXCEPTION_EN
            e_exc      <= '0;
`endif
        end else begin
            head <= head + n_ret;
            tail <= tail + n_acc;
            for (int e = 0; e < N_ROB; e++) begin
                for (int c = 0; c < N_CDB; c++) begin
                    if (e_valid[e] && rob.cdb_valid[c] && rob.cdb_tag[c*TAG_W +: TAG_W] != '0 &&
                        rob.cdb_tag[c*TAG_W +: TAG_W] == e_tag[e]) begin
                        e_complete[e] <= 1'b1;
                        if (e_branch[e] && rob.cdb_mispred[c]) e_mispred[e] <= 1'b1;
`ifdef ROB_EXCEPTION_EN
                        if (rob.cdb_exc[c]) e_exc[e] <= 1'b1;
`endif
                    end
                end
            end
            for (int i = 0; i < N_WAY; i++) begin
                if (rob.ret_valid[i]) e_valid[ret_idx[i]] <= 1'b0;
            end
            for (int k = 0; k < N_WAY; k++) begin
                if (rob.dis_accept[k]) begin
                    e_valid[dis_slot[k]]    <= 1'b1;
                    e_complete[dis_slot[k]] <= 1'b0;
                    e_mispred[dis_slot[k]]  <= 1'b0;
                    e_branch[dis_slot[k]]   <= rob.dis_branch[k];
                    e_tag[dis_slot[k]]      <= rob.dis_tag[k*TAG_W +: TAG_W];
                    e_told[dis_slot[k]]     <= rob.dis_told[k*TAG_W +: TAG_W];
`ifdef ROB_EXCEPTION_EN
                    e_exc[dis_slot[k]]      <= 1'b0;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_rob_nway_ptr.sv
// Directed bench for rob_nway_ptr: fill/full, out-of-order completion, wrap,
// mispredict squash and mid-stream reset, all with hand-computed expectations.
module tb_rob_nway_ptr;
    localparam int N_WAY = 2;
    localparam int N_ROB = 32;
    localparam int N_CDB = 2;
    localparam int TAG_W = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    rob_nway_ptr_if #(.N_WAY(N_WAY), .N_ROB(N_ROB), .N_CDB(N_CDB), .TAG_W(TAG_W)) rif ();

    rob_nway_ptr #(.N_WAY(N_WAY), .N_ROB(N_ROB), .N_CDB(N_CDB), .TAG_W(TAG_W)) dut (
        .clock (clock),
        .reset (reset),
        .rob   (rif.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic dis(input logic [1:0] v, input logic [5:0] t0, input logic [5:0] t1,
                       input logic [1:0] br);
        rif.dis_valid  = v;
        rif.dis_tag    = {t1, t0};
        rif.dis_told   = {~t1, ~t0};
        rif.dis_branch = br;
    endtask

    task automatic cdb(input logic [1:0] v, input logic [5:0] t0, input logic [5:0] t1,
                       input logic [1:0] mp);
        rif.cdb_valid   = v;
        rif.cdb_tag     = {t1, t0};
        rif.cdb_mispred = mp;
    endtask

    task automatic idle();
        dis(2'b00, 6'd0, 6'd0, 2'b00);
        cdb(2'b00, 6'd0, 6'd0, 2'b00);
    endtask

    logic [N_ROB*TAG_W-1:0] exp_st;
    int exp_occ;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
`ifdef ROB_EXCEPTION_EN
        rif.cdb_exc = '0;
`endif
        idle();
        reset = 1'b0;
        tick();
        tick();
        #1;
        check("rst_occ", rif.occupancy, 0);
        check("rst_free", rif.dis_free_cnt, 2);
        check("rst_ret_valid", rif.ret_valid, 0);
        check("rst_ret_tag", rif.ret_tag, 0);
        check("rst_ret_told", rif.ret_told, 0);
        check("rst_squash", rif.squash, 0);
        check("rst_squash_vec", rif.squash_vec, 0);
        check("rst_squash_tags", rif.squash_tags, 0);
        check("rst_accept", rif.dis_accept, 0);
        reset = 1'b1;

        // fill to full with tags 1..32
        for (int c = 0; c < 16; c++) begin
            dis(2'b11, 6'(2*c+1), 6'(2*c+2), 2'b00);
            #1;
            check("fill_accept", rif.dis_accept, 2'b11);
            check("fill_occ", rif.occupancy, 2*c);
            tick();
        end
        dis(2'b11, 6'd33, 6'd34, 2'b00);
        #1;
        check("full_occ", rif.occupancy, 32);
        check("full_free", rif.dis_free_cnt, 0);
        check("full_accept", rif.dis_accept, 2'b00);

        // out-of-order completion 3, 1, 2
        cdb(2'b01, 6'd3, 6'd0, 2'b00);
        #1;
        check("ooo_c1_ret", rif.ret_valid, 2'b00);
        tick();
        cdb(2'b01, 6'd1, 6'd0, 2'b00);
        #1;
        check("ooo_c2_ret", rif.ret_valid, 2'b00);
        tick();
        cdb(2'b00, 6'd0, 6'd0, 2'b00);
        #1;
        check("ooo_c3_ret", rif.ret_valid, 2'b01);
        check("ooo_c3_tag", rif.ret_tag[5:0], 1);
        check("ooo_c3_told", rif.ret_told[5:0], 62);
        check("ooo_c3_accept", rif.dis_accept, 2'b00);
        tick();
        cdb(2'b01, 6'd2, 6'd0, 2'b00);
        #1;
        check("ooo_c4_ret", rif.ret_valid, 2'b00);
        check("one_free_occ", rif.occupancy, 31);
        check("one_free_cnt", rif.dis_free_cnt, 1);
        check("one_free_accept", rif.dis_accept, 2'b01);
        tick();
        idle();
        #1;
        check("ooo_c5_ret", rif.ret_valid, 2'b11);
        check("ooo_c5_tags", rif.ret_tag, {6'd3, 6'd2});
        check("ooo_c5_told", rif.ret_told, {~6'd3, ~6'd2});
        check("ooo_c5_occ", rif.occupancy, 32);
        tick();
        #1;
        check("ooo_c6_occ", rif.occupancy, 30);
        check("ooo_c6_ret", rif.ret_valid, 2'b00);
        check("ooo_c6_free", rif.dis_free_cnt, 2);

        // reset discards contents
        reset = 1'b0;
        tick();
        #1;
        check("rst2_occ", rif.occupancy, 0);
        check("rst2_ret", rif.ret_valid, 0);
        reset = 1'b1;

        // 20 pairs with retires interleaved; pointers wrap past entry 31
        exp_occ = 0;
        for (int i = 0; i < 22; i++) begin
            if (i < 20) dis(2'b11, 6'(2*i+1), 6'(2*i+2), 2'b00);
            else        dis(2'b00, 6'd0, 6'd0, 2'b00);
            if (i >= 1 && i <= 20) cdb(2'b11, 6'(2*i-1), 6'(2*i), 2'b00);
            else                   cdb(2'b00, 6'd0, 6'd0, 2'b00);
            #1;
            check("wrap_occ", rif.occupancy, exp_occ);
            if (i < 20) check("wrap_accept", rif.dis_accept, 2'b11);
            if (i >= 2) begin
                check("wrap_ret", rif.ret_valid, 2'b11);
                check("wrap_tags", rif.ret_tag, {6'(2*i-2), 6'(2*i-3)});
                check("wrap_told", rif.ret_told, {~6'(2*i-2), ~6'(2*i-3)});
            end else begin
                check("wrap_ret", rif.ret_valid, 2'b00);
            end
            exp_occ = exp_occ + ((i < 20) ? 2 : 0) - ((i >= 2) ? 2 : 0);
            tick();
        end
        #1;
        check("wrap_end_occ", rif.occupancy, 0);

        // mispredicted branch tag 5 at index 4, six younger entries
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            dis(2'b11, 6'(2*k+1), 6'(2*k+2), (k == 2) ? 2'b01 : 2'b00);
            tick();
        end
        dis(2'b01, 6'd11, 6'd0, 2'b00);
        tick();
        idle();
        cdb(2'b11, 6'd1, 6'd2, 2'b00);
        tick();
        cdb(2'b11, 6'd3, 6'd4, 2'b00);
        #1;
        check("br_ret12", rif.ret_tag, {6'd2, 6'd1});
        tick();
        cdb(2'b01, 6'd5, 6'd0, 2'b01);
        #1;
        check("br_ret34", rif.ret_tag, {6'd4, 6'd3});
        tick();
        dis(2'b11, 6'd20, 6'd21, 2'b00);
        cdb(2'b01, 6'd6, 6'd0, 2'b00);
        exp_st = '0;
        for (int e = 5; e <= 10; e++) exp_st[e*TAG_W +: TAG_W] = 6'(e + 1);
        #1;
        check("sq_ret_valid", rif.ret_valid, 2'b01);
        check("sq_ret_tag", rif.ret_tag[5:0], 5);
        check("sq_squash", rif.squash, 1);
        check("sq_vec", rif.squash_vec, 32'h0000_07E0);
        check("sq_tags", rif.squash_tags, exp_st);
        check("sq_accept", rif.dis_accept, 2'b00);
        check("sq_occ", rif.occupancy, 7);
        tick();
        idle();
        #1;
        check("post_sq_occ", rif.occupancy, 0);
        check("post_sq_squash", rif.squash, 0);
        check("post_sq_ret", rif.ret_valid, 0);
        check("post_sq_free", rif.dis_free_cnt, 2);
        // branch 20 should land at index 5, so its younger neighbour marks bit 6
        dis(2'b11, 6'd20, 6'd21, 2'b01);
        tick();
        idle();
        cdb(2'b01, 6'd20, 6'd0, 2'b01);
        #1;
        check("resume_occ", rif.occupancy, 2);
        tick();
        idle();
        #1;
        check("resume_squash", rif.squash, 1);
        check("resume_vec", rif.squash_vec, 32'h0000_0040);
        check("resume_ret_tag", rif.ret_tag[5:0], 20);
        tick();

        // mid-stream reset with 10 entries and a pending completion
        for (int k = 0; k < 5; k++) begin
            dis(2'b11, 6'(30+2*k), 6'(31+2*k), 2'b00);
            tick();
        end
        idle();
        cdb(2'b01, 6'd30, 6'd0, 2'b00);
        reset = 1'b0;
        #1;
        check("mid_pre_occ", rif.occupancy, 10);
        tick();
        idle();
        #1;
        check("mid_occ", rif.occupancy, 0);
        check("mid_squash", rif.squash, 0);
        check("mid_ret", rif.ret_valid, 0);
        check("mid_free", rif.dis_free_cnt, 2);
        reset = 1'b1;
        tick();
        #1;
        check("mid_after_ret", rif.ret_valid, 0);
        check("mid_after_occ", rif.occupancy, 0);
        check("mid_after_squash", rif.squash, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
